// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S slave receiver.
// Holds the default sample width, the channel codes and the FSM state type.
package i2s_pkg;

    localparam int DATA_WIDTH_DEF = 24;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ALIGN,
        DELAY,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for signals entering the axis_clk domain.
// Cleared asynchronously so no stale level survives a reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples sclk/lrck/sdin in the axis_clk domain
// and presents each completed sample on an AXI-Stream style output.
module i2s_slave_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  axis_clk,
    input  logic                  axis_reset,
    input  logic                  i2s_sclk,
    input  logic                  i2s_lrck,
    input  logic                  i2s_sdin,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  overflow,
    output logic                  short_word
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic sclk_s, lrck_s, sdin_s;
    logic sclk_q, lrck_q;
    logic rise, lr_chg, lr_fall;

    state_t          state_q, state_d;
    logic            chan_q, chan_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic            complete, short_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic            valid_q, last_q, ovf_q, short_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(axis_clk), .rst_i(axis_reset), .d_i(i2s_sclk), .q_o(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk_i(axis_clk), .rst_i(axis_reset), .d_i(i2s_lrck), .q_o(lrck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk_i(axis_clk), .rst_i(axis_reset), .d_i(i2s_sdin), .q_o(sdin_s)
    );

    // lrck_q holds the word select seen on the previous sclk rising edge
    assign rise    = sclk_s & ~sclk_q;
    assign lr_chg  = lrck_s ^ lrck_q;
    assign lr_fall = lrck_q & ~lrck_s;

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q <= ALIGN;
            sclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            chan_q  <= LEFT;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_s;
            if (rise) begin
                lrck_q <= lrck_s;
            end
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise) begin
            unique case (state_q)
                ALIGN: if (lr_fall) state_d = DELAY;
                DELAY: state_d = SHIFT;
                SHIFT: begin
                    if (lr_chg) begin
                        state_d = DELAY;
                    end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = HOLD;
                    end
                end
                HOLD:  if (lr_chg) state_d = DELAY;
            endcase
        end
    end

    always_comb begin
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        complete = 1'b0;
        short_d  = 1'b0;
        if (rise) begin
            unique case (state_q)
                ALIGN: if (lr_fall) chan_d = LEFT;
                DELAY: begin
                    cnt_d = '0;
                    sh_d  = '0;
                end
                SHIFT: begin
                    if (lr_chg) begin
                        chan_d  = lrck_s;
                        short_d = 1'b1;
                    end else begin
                        sh_d     = DATA_WIDTH'({sh_q, sdin_s});
                        cnt_d    = cnt_q + CW'(1);
                        complete = (cnt_q == CW'(DATA_WIDTH - 1));
                    end
                end
                HOLD:  if (lr_chg) chan_d = lrck_s;
            endcase
        end
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            short_q <= short_d;
            if (complete && (!valid_q || m_axis_ready)) begin
                data_q  <= sh_d;
                last_q  <= chan_q;
                valid_q <= 1'b1;
            end else if (complete) begin
                ovf_q   <= 1'b1;
            end else if (valid_q && m_axis_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_data  = data_q;
    assign m_axis_valid = valid_q;
    assign m_axis_last  = last_q;
    assign overflow     = ovf_q;
    assign short_word   = short_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: table of stereo words plus
// hand-written sequences for short words, backpressure and reset.
module tb_i2s_slave_rx;

    logic        axis_clk = 1'b0;
    logic        axis_reset = 1'b1;
    logic        i2s_sclk = 1'b0;
    logic        i2s_lrck = 1'b1;
    logic        i2s_sdin = 1'b0;
    logic [23:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b1;
    logic        m_axis_last;
    logic        overflow;
    logic        short_word;

    i2s_slave_rx dut (
        .axis_clk    (axis_clk),
        .axis_reset  (axis_reset),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdin    (i2s_sdin),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last),
        .overflow    (overflow),
        .short_word  (short_word)
    );

    always #5 axis_clk = ~axis_clk;

    int errors = 0;
    int checks = 0;
    int short_cnt = 0;
    logic [24:0] outq[$];

    always @(negedge axis_clk) begin
        if (!axis_reset && m_axis_valid && m_axis_ready)
            outq.push_back({m_axis_last, m_axis_data});
        if (short_word) short_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // sclk at axis_clk/8; lrck and sdin change while sclk is low
    task automatic bit_edge(input logic lr, input logic d);
        i2s_sclk = 1'b0;
        i2s_lrck = lr;
        i2s_sdin = d;
        #40;
        i2s_sclk = 1'b1;
        #40;
    endtask

    // edge 0 shows the new lrck, edge 1 is the one-bit delay, then data
    task automatic send_word(input logic lr, input logic [23:0] w,
                             input int nbits, input logic pad);
        bit_edge(lr, ~w[23]);
        bit_edge(lr, ~w[23]);
        for (int i = 0; i < nbits; i++)
            bit_edge(lr, (i < 24) ? w[23 - i] : pad);
    endtask

    task automatic chk_one(input string name, input logic [23:0] d,
                           input logic l);
        logic [24:0] e;
        chk({name, "_count"}, outq.size(), 1);
        e = (outq.size() > 0) ? outq.pop_front() : 'x;
        chk({name, "_data"}, e[23:0], d);
        chk({name, "_last"}, e[24], l);
        outq.delete();
    endtask

    typedef struct {
        logic        lr;
        logic [23:0] w;
        int          nbits;
        logic        pad;
        logic [23:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b0, 24'hA5A5A5, 32, 1'b0, 24'hA5A5A5, 1'b0};
        vt[1] = '{1'b1, 24'h5A5A5A, 32, 1'b0, 24'h5A5A5A, 1'b1};
        vt[2] = '{1'b0, 24'hFFF000, 32, 1'b1, 24'hFFF000, 1'b0};
        vt[3] = '{1'b1, 24'h123456, 32, 1'b0, 24'h123456, 1'b1};
        vt[4] = '{1'b0, 24'h800001, 26, 1'b1, 24'h800001, 1'b0};
        vt[5] = '{1'b1, 24'hFFFFFF, 32, 1'b0, 24'hFFFFFF, 1'b1};

        // reset state
        repeat (3) @(posedge axis_clk);
        #1;
        chk("rst_valid", m_axis_valid, 0);
        chk("rst_data", m_axis_data, 0);
        chk("rst_last", m_axis_last, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_short", short_word, 0);
        @(negedge axis_clk);
        axis_reset = 1'b0;

        // stereo frames with ready high
        for (int i = 0; i < 4; i++) bit_edge(1'b1, 1'b0);
        outq.delete();
        for (int i = 0; i < 6; i++) begin
            send_word(vt[i].lr, vt[i].w, vt[i].nbits, vt[i].pad);
            chk_one($sformatf("vec%0d", i), vt[i].exp_data, vt[i].exp_last);
        end
        chk("tbl_ovf", overflow, 0);

        // left word cut short after 10 bits
        short_cnt = 0;
        send_word(1'b0, 24'hFFFFFF, 10, 1'b0);
        chk("short_nout", outq.size(), 0);
        send_word(1'b1, 24'h123456, 32, 1'b0);
        chk("short_pulses", short_cnt, 1);
        chk_one("after_short", 24'h123456, 1'b1);

        // backpressure across two completed words
        @(posedge axis_clk);
        #1 m_axis_ready = 1'b0;
        send_word(1'b0, 24'h000001, 32, 1'b0);
        chk("bp1_valid", m_axis_valid, 1);
        chk("bp1_data", m_axis_data, 24'h000001);
        chk("bp1_ovf", overflow, 0);
        send_word(1'b1, 24'h800000, 32, 1'b0);
        chk("bp2_valid", m_axis_valid, 1);
        chk("bp2_data", m_axis_data, 24'h000001);
        chk("bp2_last", m_axis_last, 0);
        chk("bp2_ovf", overflow, 1);
        outq.delete();
        @(posedge axis_clk);
        #1 m_axis_ready = 1'b1;
        repeat (6) @(posedge axis_clk);
        #1;
        chk("bp_valid_fall", m_axis_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);
        chk_one("bp_xfer", 24'h000001, 1'b0);

        // reset while a sample is held under backpressure
        m_axis_ready = 1'b0;
        send_word(1'b0, 24'h000AAA, 32, 1'b0);
        chk("pre_rst_valid", m_axis_valid, 1);
        @(posedge axis_clk);
        #2 axis_reset = 1'b1;
        #1;
        chk("async_valid", m_axis_valid, 0);
        chk("async_data", m_axis_data, 0);
        chk("async_ovf", overflow, 0);

        // release reset partway through a right word
        m_axis_ready = 1'b1;
        outq.delete();
        bit_edge(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) bit_edge(1'b1, 1'b1);
        @(negedge axis_clk);
        axis_reset = 1'b0;
        for (int i = 0; i < 20; i++) bit_edge(1'b1, i[0]);
        chk("realign_nout", outq.size(), 0);
        send_word(1'b0, 24'h0ABCDE, 32, 1'b0);
        chk_one("realign", 24'h0ABCDE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
